// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready EX/MEM-class stage register with an optional
// 2-entry skid buffer, synchronous flush (bubble insert) and start gating.
module pipe_stage_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [1:0]        count_o
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  beat_t  m;
  beat_t  s;
  beat_t  in_beat;
  logic   push;
  logic   pop;

  assign in_beat = {ctrl_i, data_i, wdata_i, rd_i};

  // Skid build: ready depends only on registered state, cutting the
  // combinational path from out_ready_i back upstream.
  if (SKID) begin : g_skid
    assign in_ready_o = start_i & (state != FULL);
  end else begin : g_single
    assign in_ready_o = start_i & ((state == EMPTY) | out_ready_i);
  end

  assign out_valid_o = (state != EMPTY);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= EMPTY;
      m     <= '0;
      s     <= '0;
    end else if (flush_i) begin
      state <= EMPTY;
      m     <= '0;
      s     <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            m     <= in_beat;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            m <= in_beat;
          end else if (push && SKID) begin
            s     <= in_beat;
            state <= FULL;
          end else if (pop) begin
            m     <= '0;
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            m     <= s;
            s     <= '0;
            state <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
          m     <= '0;
          s     <= '0;
        end
      endcase
    end
  end

  // Bubbles carry no control bits so downstream sees no side effects.
  assign ctrl_o  = out_valid_o ? m.ctrl : '0;
  assign data_o  = m.data;
  assign wdata_o = m.wdata;
  assign rd_o    = m.rd;
  assign count_o = state;

endmodule
